// File: rtl/lc3b_scoreboard.sv
// lc3b_scoreboard: per-register pending-writer counters for the LC-3b decode
// stall check. Each issue from decode that writes a register (or CC) bumps
// that register's counter, and the matching writeback commit decrements it.
// Decode stalls while any needed source (or CC for a branch) is still pending.
//
// Optional feature macro: LC3B_SCOREBOARD_RETIRE_BYPASS_EN
//   When defined, a register whose last pending writer commits this cycle is
//   treated as free by dep_stall in that same cycle, which matches the
//   write-first register file. reg_busy/cc_busy always show the registered
//   counter state.
module lc3b_scoreboard #(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid,
    input  logic       issue_ld_reg,
    input  logic [2:0] issue_drid,
    input  logic       issue_ld_cc,
    input  logic       wb_valid,
    input  logic       wb_ld_reg,
    input  logic [2:0] wb_drid,
    input  logic       wb_ld_cc,
    input  logic       flush,
    input  logic       q_valid,
    input  logic [2:0] q_sr1,
    input  logic [2:0] q_sr2,
    input  logic       q_sr1_needed,
    input  logic       q_sr2_needed,
    input  logic [3:0] q_opcode,
    output logic       dep_stall,
    output logic [7:0] reg_busy,
    output logic       cc_busy,
    output logic       sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       OP_BR   = 4'b0000;

    logic [CNT_W-1:0] cnt [8];
    logic [CNT_W-1:0] cc_cnt;
    logic             err;

    logic [7:0] inc_vec;
    logic [7:0] dec_vec;
    logic [7:0] free_vec;
    logic [7:0] stall_busy;
    logic       cc_inc;
    logic       cc_dec;
    logic       cc_free;
    logic       cc_stall_busy;

    // Decode issue/writeback events into per-register increment/decrement strobes
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue_valid && issue_ld_reg) inc_vec[issue_drid] = 1'b1;
        if (wb_valid && wb_ld_reg)       dec_vec[wb_drid]    = 1'b1;
        cc_inc = issue_valid & issue_ld_cc;
        cc_dec = wb_valid & wb_ld_cc;
    end

    // Pending-writer counters with saturation and a sticky over/underflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
            cc_cnt <= '0;
            err    <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
            cc_cnt <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    if (cnt[i] == CNT_MAX) err <= 1'b1;
                    else                   cnt[i] <= cnt[i] + CNT_ONE;
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    if (cnt[i] == '0) err <= 1'b1;
                    else              cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
            if (cc_inc && !cc_dec) begin
                if (cc_cnt == CNT_MAX) err <= 1'b1;
                else                   cc_cnt <= cc_cnt + CNT_ONE;
            end else if (cc_dec && !cc_inc) begin
                if (cc_cnt == '0) err <= 1'b1;
                else              cc_cnt <= cc_cnt - CNT_ONE;
            end
        end
    end

    // Registered busy view of every counter
    always_comb begin
        reg_busy = '0;
        for (int i = 0; i < 8; i++) reg_busy[i] = (cnt[i] != '0);
        cc_busy = (cc_cnt != '0);
    end

`ifdef LC3B_SCOREBOARD_RETIRE_BYPASS_EN
    // A last pending writer committing this cycle frees its register for decode now
    always_comb begin
        free_vec = '0;
        for (int i = 0; i < 8; i++)
            free_vec[i] = (cnt[i] == CNT_ONE) & dec_vec[i] & ~inc_vec[i];
        cc_free = (cc_cnt == CNT_ONE) & cc_dec & ~cc_inc;
    end
`else
    // Without bypass decode waits for the registered counter to drop
    always_comb begin
        free_vec = '0;
        cc_free  = 1'b0;
    end
`endif

    // Decode stall when a needed source or the branch CC still has a pending writer
    always_comb begin
        stall_busy    = reg_busy & ~free_vec;
        cc_stall_busy = cc_busy & ~cc_free;
        dep_stall     = q_valid & ((q_sr1_needed & stall_busy[q_sr1]) |
                                   (q_sr2_needed & stall_busy[q_sr2]) |
                                   ((q_opcode == OP_BR) & cc_stall_busy));
    end

    assign sb_err = err;

endmodule

// File: tb/tb_lc3b_scoreboard.sv
// Bench for lc3b_scoreboard: a reference model predicts every output and a
// scoreboard queue pairs each prediction with the DUT response.
module tb_lc3b_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       issue_valid, issue_ld_reg, issue_ld_cc;
    logic [2:0] issue_drid;
    logic       wb_valid, wb_ld_reg, wb_ld_cc;
    logic [2:0] wb_drid;
    logic       flush;
    logic       q_valid, q_sr1_needed, q_sr2_needed;
    logic [2:0] q_sr1, q_sr2;
    logic [3:0] q_opcode;
    logic       dep_stall;
    logic [7:0] reg_busy;
    logic       cc_busy;
    logic       sb_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] rb;
        logic       cc;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    logic ds_q[$];

    int m_cnt[8];
    int m_cc;
    bit m_err;

    lc3b_scoreboard #(.MAX_INFLIGHT(3), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ld_reg(issue_ld_reg),
        .issue_drid(issue_drid), .issue_ld_cc(issue_ld_cc),
        .wb_valid(wb_valid), .wb_ld_reg(wb_ld_reg),
        .wb_drid(wb_drid), .wb_ld_cc(wb_ld_cc),
        .flush(flush),
        .q_valid(q_valid), .q_sr1(q_sr1), .q_sr2(q_sr2),
        .q_sr1_needed(q_sr1_needed), .q_sr2_needed(q_sr2_needed),
        .q_opcode(q_opcode),
        .dep_stall(dep_stall), .reg_busy(reg_busy),
        .cc_busy(cc_busy), .sb_err(sb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int upd(int c, bit inc, bit dec);
        int n = c;
        if (inc && !dec) begin
            if (c == 3) m_err = 1'b1;
            else        n = c + 1;
        end else if (dec && !inc) begin
            if (c == 0) m_err = 1'b1;
            else        n = c - 1;
        end
        return n;
    endfunction

    function automatic bit m_reg_stall(int r);
        bit b = (m_cnt[r] != 0);
`ifdef LC3B_SCOREBOARD_RETIRE_BYPASS_EN
        if (m_cnt[r] == 1 && wb_valid && wb_ld_reg && int'(wb_drid) == r &&
            !(issue_valid && issue_ld_reg && int'(issue_drid) == r)) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic bit m_cc_stall();
        bit b = (m_cc != 0);
`ifdef LC3B_SCOREBOARD_RETIRE_BYPASS_EN
        if (m_cc == 1 && wb_valid && wb_ld_cc && !(issue_valid && issue_ld_cc)) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic bit m_dep_stall();
        if (!q_valid) return 1'b0;
        return (q_sr1_needed && m_reg_stall(int'(q_sr1))) ||
               (q_sr2_needed && m_reg_stall(int'(q_sr2))) ||
               (q_opcode == 4'b0000 && m_cc_stall());
    endfunction

    function automatic exp_t m_view();
        exp_t e;
        for (int i = 0; i < 8; i++) e.rb[i] = (m_cnt[i] != 0);
        e.cc  = (m_cc != 0);
        e.err = m_err;
        return e;
    endfunction

    function automatic void m_step();
        if (flush) begin
            for (int i = 0; i < 8; i++) m_cnt[i] = 0;
            m_cc = 0;
        end else begin
            for (int i = 0; i < 8; i++)
                m_cnt[i] = upd(m_cnt[i],
                               issue_valid && issue_ld_reg && int'(issue_drid) == i,
                               wb_valid && wb_ld_reg && int'(wb_drid) == i);
            m_cc = upd(m_cc, issue_valid && issue_ld_cc, wb_valid && wb_ld_cc);
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_cc  = 0;
        m_err = 1'b0;
    endfunction

    task automatic drive(input bit iv, input bit ilr, input logic [2:0] id, input bit ilc,
                         input bit wv, input bit wlr, input logic [2:0] wd, input bit wlc,
                         input bit fl);
        issue_valid = iv; issue_ld_reg = ilr; issue_drid = id; issue_ld_cc = ilc;
        wb_valid = wv; wb_ld_reg = wlr; wb_drid = wd; wb_ld_cc = wlc;
        flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 3'd0, 0, 0, 0, 3'd0, 0, 0);
    endtask

    task automatic query(input bit qv, input logic [2:0] s1, input bit n1,
                         input logic [2:0] s2, input bit n2, input logic [3:0] op);
        q_valid = qv; q_sr1 = s1; q_sr1_needed = n1;
        q_sr2 = s2; q_sr2_needed = n2; q_opcode = op;
    endtask

    // One cycle: check dep_stall with the current inputs, clock, then check registered outputs.
    task automatic tick(input string tag);
        exp_t e;
        #1;
        ds_q.push_back(m_dep_stall());
        chk({tag, ".dep_stall"}, 32'(dep_stall), 32'(ds_q.pop_front()));
        m_step();
        exp_q.push_back(m_view());
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, ".reg_busy"}, 32'(reg_busy), 32'(e.rb));
        chk({tag, ".cc_busy"},  32'(cc_busy),  32'(e.cc));
        chk({tag, ".sb_err"},   32'(sb_err),   32'(e.err));
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        query(0, 3'd0, 0, 3'd0, 0, 4'b0001);
        m_reset();
        #2;
        chk("reset.reg_busy", 32'(reg_busy), 32'h0);
        chk("reset.cc_busy", 32'(cc_busy), 32'h0);
        chk("reset.sb_err", 32'(sb_err), 32'h0);
        chk("reset.dep_stall", 32'(dep_stall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Issue R3, hold a dependent query on sr1=R3, retire R3 later
        query(1, 3'd3, 1, 3'd0, 0, 4'b0001);
        drive(1, 1, 3'd3, 0, 0, 0, 3'd0, 0, 0);
        tick("raw.issue");
        idle();
        tick("raw.wait1");
        tick("raw.wait2");
        tick("raw.wait3");
        drive(0, 0, 3'd0, 0, 1, 1, 3'd3, 0, 0);
        tick("raw.retire");
        idle();
        tick("raw.after");
        chk("raw.free", 32'(dep_stall), 32'h0);

        // Simultaneous issue and retire on R2 holds the count
        query(1, 3'd2, 1, 3'd5, 1, 4'b0001);
        drive(1, 1, 3'd2, 0, 0, 0, 3'd0, 0, 0);
        tick("same.issue");
        drive(1, 1, 3'd2, 0, 1, 1, 3'd2, 0, 0);
        tick("same.both");
        drive(0, 0, 3'd0, 0, 1, 1, 3'd2, 0, 0);
        tick("same.retire");
        idle();
        tick("same.idle");

        // CC dependency for a branch, none for an ADD on free sources
        query(1, 3'd6, 0, 3'd7, 0, 4'b0000);
        drive(1, 0, 3'd0, 1, 0, 0, 3'd0, 0, 0);
        tick("cc.issue");
        idle();
        tick("cc.br");
        query(1, 3'd6, 1, 3'd7, 1, 4'b0001);
        tick("cc.add");
        query(1, 3'd6, 0, 3'd7, 0, 4'b0000);
        drive(0, 0, 3'd0, 0, 1, 0, 3'd0, 1, 0);
        tick("cc.retire");
        idle();
        tick("cc.idle");

        // Flush beats a same-cycle issue; then an underflow sets the sticky error
        query(1, 3'd4, 1, 3'd5, 1, 4'b0000);
        drive(1, 1, 3'd4, 1, 0, 0, 3'd0, 0, 0);
        tick("flush.i1");
        drive(1, 1, 3'd4, 0, 0, 0, 3'd0, 0, 0);
        tick("flush.i2");
        drive(1, 1, 3'd5, 0, 0, 0, 3'd0, 0, 1);
        tick("flush.flush");
        drive(0, 0, 3'd0, 0, 1, 1, 3'd0, 0, 0);
        tick("flush.underflow");
        idle();
        tick("flush.idle");

        // Build cnt[3]=2 then assert reset asynchronously between edges
        query(1, 3'd3, 1, 3'd0, 0, 4'b0001);
        drive(1, 1, 3'd3, 0, 0, 0, 3'd0, 0, 0);
        tick("areset.i1");
        tick("areset.i2");
        idle();
        #3;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("areset.reg_busy", 32'(reg_busy), 32'h0);
        chk("areset.sb_err", 32'(sb_err), 32'h0);
        chk("areset.dep_stall", 32'(dep_stall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Four issues to R1: saturate at three and flag the overflow
        query(1, 3'd1, 1, 3'd0, 0, 4'b0001);
        drive(1, 1, 3'd1, 0, 0, 0, 3'd0, 0, 0);
        tick("ovf.i1");
        tick("ovf.i2");
        tick("ovf.i3");
        tick("ovf.i4");
        drive(0, 0, 3'd0, 0, 1, 1, 3'd1, 0, 0);
        tick("ovf.r1");
        tick("ovf.r2");
        tick("ovf.r3");
        idle();
        tick("ovf.idle");

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  3'($urandom_range(0, 7)), $urandom_range(0, 1),
                  ($urandom_range(0, 31) == 0));
            query($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom_range(0, 1),
                  3'($urandom_range(0, 7)), $urandom_range(0, 1),
                  ($urandom_range(0, 1) != 0) ? 4'b0000 : 4'b0001);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
